uart_rx: RTL and testbench

Asynchronous serial receiver for the picorv32 system. It deserialises 8N1 frames arriving on the `rx` pin at `BAUD_RATE`, with the frame time derived from `CLK_FREQ`. Each good byte is buffered in a small FIFO and presented on a valid/ready handshake to the memory-mapped peripheral bus. It is the receiving end of the byte stream the system testbench drives onto `rx`, and it reports framing and overrun errors.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 46 ++++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and constants common to the
// receiver and transmitter.
package uart_pkg;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_DEFAULT_BAUD = 9600;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer. A push while full is accepted only
// when a pop frees a slot on the same edge; the head reads as zero when empty.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_dout    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and a small FWFT
// buffer presented on a valid/ready handshake, with framing/overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = UART_DEFAULT_BAUD,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       sys_clk,
   input  logic       sys_resetn,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT - 1);

   uart_rx_state_t            r_state;
   logic                      r_rx_meta;
   logic                      r_rx_s;
   logic [CW-1:0]             r_cnt;
   logic [2:0]                r_idx;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] r_push_data;
   logic                      r_push;
   logic                      r_frame_err;
   logic                      w_bit_end;
   logic                      w_empty;
   logic                      w_full;
   logic                      w_pop;

   assign w_bit_end = (r_cnt == LAST_CNT);

   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!r_rx_s) begin
                  r_cnt   <= '0;
                  r_state <= START;
               end
            end
            START: begin
               // A start bit that is high again at mid-bit is treated as a glitch.
               if (r_cnt == HALF_CNT) begin
                  if (r_rx_s) begin
                     r_state <= IDLE;
                  end else begin
                     r_cnt   <= '0;
                     r_idx   <= '0;
                     r_state <= DATA;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  r_idx <= r_idx + 3'd1;
                  if (r_idx == 3'd7) r_state <= STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_rx_s) begin
                     r_push  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= WAIT_HIGH;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (r_rx_s) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (r_state == DATA && w_bit_end) r_shift <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
      if (r_state == STOP && w_bit_end) r_push_data <= r_shift;
   end

   uart_rx_fifo #(
      .WIDTH(UART_DATA_BITS),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .i_clk  (sys_clk),
      .i_rst_n(sys_resetn),
      .i_push (r_push),
      .i_data (r_push_data),
      .i_pop  (w_pop),
      .o_dout (rx_data),
      .o_empty(w_empty),
      .o_full (w_full)
   );

   // Overrun is flagged in the push cycle itself, so a same-cycle pop rescues the byte.
   assign w_pop     = rx_valid && rx_ready;
   assign rx_valid  = !w_empty;
   assign overrun   = r_push && w_full && !w_pop;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: cycle-stamped frame events feed a queue
// model of the receive buffer that is compared against the DUT every cycle.
module tb_uart_rx;

   localparam int CLK_FREQ = 320000;
   localparam int BAUD     = 10000;
   localparam int DEPTH    = 4;
   localparam int C        = CLK_FREQ / BAUD;
   localparam int H        = C / 2;
   // From the cycle the start edge is driven to the cycle after the stop decision.
   localparam int LAT      = 3 + H + 9 * C;

   logic       sys_clk    = 1'b0;
   logic       sys_resetn = 1'b0;
   logic       rx         = 1'b1;
   logic       rx_ready   = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   typedef struct {
      int         d;
      bit         good;
      logic [7:0] data;
   } ev_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   ev_t        evq[$];
   logic [7:0] mq[$];
   logic [7:0] got[$];
   int         ferr_seen = 0;
   int         ovr_seen  = 0;
   int         busy_cnt  = 0;
   int         rise_cyc  = -1;
   bit         prev_valid = 1'b0;
   int         pb_lo = 0, pb_hi = 0, cb_lo = 0, cb_hi = 0;
   bit         rand_ready = 1'b0;

   uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_resetn(sys_resetn),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference: receive buffer as a queue, frame outcomes as timestamped events.
   always @(negedge sys_clk) begin : compare
      bit         exp_busy;
      bit         pop;
      bit         ev_now;
      ev_t        ev;
      if (!sys_resetn) begin
         chk("rst_rx_valid", rx_valid, 0);
         chk("rst_rx_data", rx_data, 0);
         chk("rst_frame_err", frame_err, 0);
         chk("rst_overrun", overrun, 0);
         chk("rst_busy", busy, 0);
         mq.delete();
         evq.delete();
         pb_hi = 0;
         cb_hi = 0;
         prev_valid = 1'b0;
      end else begin
         exp_busy = (cyc >= pb_lo && cyc < pb_hi) || (cyc >= cb_lo && cyc < cb_hi);
         ev_now   = 1'b0;
         if (evq.size() > 0) begin
            ev = evq[0];
            ev_now = (ev.d == cyc);
         end
         pop = (mq.size() > 0) && rx_ready;
         chk("rx_valid", rx_valid, (mq.size() != 0) ? 1 : 0);
         chk("rx_data", rx_data, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
         chk("busy", busy, exp_busy);
         chk("frame_err", frame_err, (ev_now && !ev.good) ? 1 : 0);
         chk("overrun", overrun, (ev_now && ev.good && mq.size() == DEPTH && !pop) ? 1 : 0);
         if (frame_err) ferr_seen++;
         if (overrun) ovr_seen++;
         if (busy) busy_cnt++;
         if (rx_valid && !prev_valid) rise_cyc = cyc;
         prev_valid = rx_valid;
         if (rx_valid && rx_ready) got.push_back(rx_data);
         if (pop) void'(mq.pop_front());
         if (ev_now) begin
            void'(evq.pop_front());
            if (ev.good && mq.size() < DEPTH) mq.push_back(ev.data);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
         if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send(input logic [7:0] b, input bit stop, input int hold_low, input bit rec);
      int  f;
      ev_t e;
      f = cyc;
      pb_lo = cb_lo; pb_hi = cb_hi;
      cb_lo = f + 3;
      cb_hi = stop ? f + LAT : 32'h7fffffff;
      if (rec) begin
         e.d = f + LAT; e.good = stop; e.data = b;
         evq.push_back(e);
      end
      rx = 1'b0;
      wait_cyc(C);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(C);
      end
      rx = stop;
      wait_cyc(C);
      if (!stop) wait_cyc(hold_low);
      rx = 1'b1;
      if (!stop) cb_hi = cyc + 3;
   endtask

   task automatic glitch(input int g);
      pb_lo = cb_lo; pb_hi = cb_hi;
      cb_lo = cyc + 3; cb_hi = cyc + 3 + H;
      rx = 1'b0;
      wait_cyc(g);
      rx = 1'b1;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: run exceeded cycle budget at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : main
      int         f0;
      int         n0;
      int         e0;
      string      s;
      logic [7:0] c;
      wait_cyc(5);
      sys_resetn = 1'b1;
      wait_cyc(3);

      // Single byte, latency pinned by hand: 3 + 16 + 9*32 + 1 = 308.
      rise_cyc = -1;
      f0 = cyc;
      send(8'h48, 1'b1, 0, 1'b1);
      wait_cyc(4);
      chk("lat_0x48", rise_cyc - f0, 308);
      chk("byte_0x48", rx_data, 8'h48);
      chk("err_0x48", ferr_seen + ovr_seen, 0);
      rx_ready = 1'b1;
      wait_cyc(1);
      rx_ready = 1'b0;
      wait_cyc(2);

      // Short start glitch: busy exactly H cycles, nothing pushed.
      busy_cnt = 0;
      glitch(H - 4);
      wait_cyc(3 * C);
      chk("glitch_busy_cycles", busy_cnt, 16);
      chk("glitch_no_push", rx_valid, 0);
      chk("glitch_no_err", ferr_seen + ovr_seen, 0);

      // Bad stop followed by a break, then a good byte.
      rx_ready = 1'b1;
      e0 = ferr_seen;
      send(8'h5A, 1'b0, 3 * C, 1'b1);
      wait_cyc(C);
      chk("break_one_ferr", ferr_seen - e0, 1);
      chk("break_fifo_empty", rx_valid, 0);
      n0 = got.size();
      send(8'h21, 1'b1, 0, 1'b1);
      wait_cyc(C);
      chk("after_break_cnt", got.size() - n0, 1);
      if (got.size() > n0) chk("after_break_byte", got[n0], 8'h21);

      // Overrun on the fifth byte, then drain 1..4.
      rx_ready = 1'b0;
      e0 = ovr_seen;
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 0, 1'b1);
      wait_cyc(C);
      chk("overrun_once", ovr_seen - e0, 1);
      n0 = got.size();
      rx_ready = 1'b1;
      wait_cyc(8);
      chk("drain_cnt", got.size() - n0, 4);
      for (int i = 0; i < 4; i++)
         if (got.size() > n0 + i) chk("drain_byte", got[n0 + i], i + 1);

      // Back-to-back string.
      s = "Hello, World!";
      n0 = got.size();
      e0 = ferr_seen + ovr_seen;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         send(c, 1'b1, 0, 1'b1);
      end
      wait_cyc(C);
      chk("hello_cnt", got.size() - n0, 13);
      chk("hello_no_err", ferr_seen + ovr_seen - e0, 0);
      for (int i = 0; i < s.len(); i++)
         if (got.size() > n0 + i) chk("hello_byte", got[n0 + i], s[i]);

      // Reset during data bit 4, then a clean 0xA5.
      rx_ready = 1'b0;
      pb_lo = cb_lo; pb_hi = cb_hi;
      cb_lo = cyc + 3; cb_hi = 32'h7fffffff;
      rx = 1'b0;
      wait_cyc(C);
      for (int i = 0; i < 4; i++) begin
         rx = 1'(8'hC3 >> i);
         wait_cyc(C);
      end
      rx = 1'b0;
      wait_cyc(H);
      sys_resetn = 1'b0;
      rx = 1'b1;
      pb_hi = 0; cb_hi = 0;
      wait_cyc(3);
      sys_resetn = 1'b1;
      wait_cyc(2);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", rx_valid, 0);
      send(8'hA5, 1'b1, 0, 1'b1);
      wait_cyc(4);
      chk("post_rst_byte", rx_data, 8'hA5);
      rx_ready = 1'b1;
      wait_cyc(2);

      // Randomized frames, stop errors and consumer back-pressure.
      rand_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         bit st;
         st = ($urandom_range(0, 7) != 0);
         send(8'($urandom), st, st ? 0 : $urandom_range(0, C), 1'b1);
         wait_cyc($urandom_range(st ? 0 : 1, H));
      end
      wait_cyc(2 * C);
      rand_ready = 1'b0;
      wait_cyc(1);
      rx_ready = 1'b1;
      wait_cyc(DEPTH + 4);
      chk("final_empty", rx_valid, 0);
      chk("final_events_done", evq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
